// File: rtl/data_memory_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 has fixed priority, port 1 is guaranteed a grant after MAX_WAIT losses.
// Each access is IDLE -> ACCESS -> RESP (ack in cycle k+2, 3 cycles/access); requesters hold req/we/addr/wdata until ack.
module data_memory_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_owner;

    logic w_any_req;
    logic w_p1_win;
    logic w_sel_we;

    assign w_any_req = p0_req | p1_req;
    assign w_p1_win  = p1_req && (!p0_req || (r_wait_cnt == WAIT_W'(MAX_WAIT)));
    assign w_sel_we  = w_p1_win ? p1_we : p0_we;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_owner    <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    if (w_any_req) begin
                        r_owner   <= w_p1_win;
                        mem_we    <= w_sel_we;
                        mem_re    <= !w_sel_we;
                        mem_addr  <= w_p1_win ? p1_addr : p0_addr;
                        mem_wdata <= w_p1_win ? p1_wdata : p0_wdata;
                        busy      <= 1'b1;
                        r_state   <= ACCESS;
                    end else begin
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                    end
                    // Counts arbitration losses only; saturates so the forced grant stays pending.
                    if (w_p1_win || !p1_req) begin
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    if (mem_re) begin
                        if (r_owner) p1_rdata <= mem_rdata;
                        else         p0_rdata <= mem_rdata;
                    end
                    p0_ack  <= !r_owner;
                    p1_ack  <= r_owner;
                    mem_we  <= 1'b0;
                    mem_re  <= 1'b0;
                    r_state <= RESP;
                end
                RESP: begin
                    p0_ack  <= 1'b0;
                    p1_ack  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural 256-word data memory (negedge write, Z when not reading).
`timescale 1ns/1ps
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p1_ack, mem_we, mem_re, busy;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
    wire  [31:0] mem_rdata;

    logic [31:0] tb_mem [0:255] = '{default: 32'h0};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = mem_re ? tb_mem[mem_addr[7:0]] : 32'hzzzz_zzzz;

    data_memory_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4), .WAIT_W(3)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_chk++; if ({p0_ack, p1_ack, mem_we, mem_re, busy} !== 5'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b want 00000", {p0_ack, p1_ack, mem_we, mem_re, busy}); end
        n_chk++; if ({p0_rdata, p1_rdata, mem_addr, mem_wdata} !== 128'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {p0_rdata, p1_rdata, mem_addr, mem_wdata}); end
        reset = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0;
        tick();
        n_chk++; if ({mem_re, mem_we, busy, p0_ack} !== 4'b1010) begin n_fail++; $display("FAIL rst_rd_access: got re/we/busy/ack %b want 1010", {mem_re, mem_we, busy, p0_ack}); end
        tick();
        n_chk++; if ({p0_ack, p1_ack, mem_re} !== 3'b100) begin n_fail++; $display("FAIL rst_rd_ack: got ack0/ack1/re %b want 100", {p0_ack, p1_ack, mem_re}); end
        n_chk++; if (p0_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 00000000", p0_rdata); end
        tick();
        p0_req = 1'b0;
        n_chk++; if ({p0_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_rd_done: got ack/busy %b want 00", {p0_ack, busy}); end
    endtask

    task automatic test_write_read();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h5; p0_wdata = 32'hDEADBEEF;
        tick();
        n_chk++; if ({mem_we, mem_re, mem_addr, mem_wdata} !== {2'b10, 32'h5, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_access: got we/re %b addr %h data %h want 10 5 deadbeef", {mem_we, mem_re}, mem_addr, mem_wdata); end
        tick();
        n_chk++; if ({mem_we, p0_ack} !== 2'b01) begin n_fail++; $display("FAIL wr_ack: got we/ack %b want 01", {mem_we, p0_ack}); end
        n_chk++; if (p0_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want 00000000", p0_rdata); end
        n_chk++; if (tb_mem[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem: got %h want deadbeef", tb_mem[5]); end
        tick();
        p0_we = 1'b0; p0_wdata = 32'h0;
        tick();
        n_chk++; if ({mem_re, mem_we} !== 2'b10) begin n_fail++; $display("FAIL rd5_access: got re/we %b want 10", {mem_re, mem_we}); end
        tick();
        n_chk++; if ({p0_ack, p0_rdata} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rd5_data: got ack %b data %h want 1 deadbeef", p0_ack, p0_rdata); end
        tick();
        p0_req = 1'b0;
    endtask

    task automatic test_p1_write();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h1FF; p1_wdata = 32'h0000_1234;
        tick();
        n_chk++; if ({mem_we, mem_addr, busy} !== {1'b1, 32'h1FF, 1'b1}) begin n_fail++; $display("FAIL p1wr_access: got we %b addr %h busy %b want 1 1ff 1", mem_we, mem_addr, busy); end
        tick();
        n_chk++; if ({p1_ack, p0_ack} !== 2'b10) begin n_fail++; $display("FAIL p1wr_ack: got ack1/ack0 %b want 10", {p1_ack, p0_ack}); end
        n_chk++; if (tb_mem[8'hFF] !== 32'h0000_1234) begin n_fail++; $display("FAIL p1wr_mem: got %h want 00001234", tb_mem[8'hFF]); end
        tick();
        p1_req = 1'b0; p1_we = 1'b0;
        n_chk++; if ({p1_ack, p0_ack} !== 2'b00) begin n_fail++; $display("FAIL p1wr_ack_pulse: got ack1/ack0 %b want 00", {p1_ack, p0_ack}); end
    endtask

    task automatic test_starvation();
        logic exp_p1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h5;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h1FF;
        for (int a = 0; a < 10; a++) begin
            tick();
            tick();
            exp_p1 = ((a % 5) == 4);
            n_chk++; if ({p1_ack, p0_ack} !== {exp_p1, !exp_p1}) begin n_fail++; $display("FAIL starve_grant%0d: got ack1/ack0 %b want %b", a, {p1_ack, p0_ack}, {exp_p1, !exp_p1}); end
            if (exp_p1) begin
                n_chk++; if (p1_rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL starve_p1_data%0d: got %h want 00001234", a, p1_rdata); end
            end else begin
                n_chk++; if (p0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL starve_p0_data%0d: got %h want deadbeef", a, p0_rdata); end
            end
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h1FF;
        tick();
        n_chk++; if ({busy, mem_re} !== 2'b11) begin n_fail++; $display("FAIL rstmid_access: got busy/re %b want 11", {busy, mem_re}); end
        reset = 1'b0;
        tick();
        n_chk++; if ({p1_ack, mem_re, busy} !== 3'b000) begin n_fail++; $display("FAIL rstmid_clear: got ack1/re/busy %b want 000", {p1_ack, mem_re, busy}); end
        n_chk++; if (p1_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 00000000", p1_rdata); end
        reset = 1'b1; p1_req = 1'b0;
        tick();
        n_chk++; if ({p1_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle: got ack1/busy %b want 00", {p1_ack, busy}); end
    endtask

    task automatic test_z_read();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0FF;
        tick();
        tick();
        n_chk++; if ({p0_ack, p0_rdata} !== {1'b1, 32'h0000_1234}) begin n_fail++; $display("FAIL zrd_data: got ack %b data %h want 1 00001234", p0_ack, p0_rdata); end
        tick();
        p0_req = 1'b0;
        tick();
        tick();
        n_chk++; if (p0_rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL zrd_hold: got %h want 00001234", p0_rdata); end
        n_chk++; if ($isunknown(p0_rdata) !== 1'b0) begin n_fail++; $display("FAIL zrd_unknown: got %h want no X/Z", p0_rdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_p1_write();
        test_starvation();
        test_reset_mid();
        test_z_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
